// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit.
// Holds the sequencer state encoding, register-index width and the
// saturating increment used by the optional performance counters.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose
// destination (other than x0) is a source of the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             hazard
);

  // Pure compare; x0 never carries a dependency.
  always_comb begin
    hazard = ex_mem_read && (ex_rd != REG_ZERO) &&
             ((ex_rd == rs1) || (ex_rd == rs2));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for hazards that forwarding cannot resolve:
// load-use stall, taken-branch flush (BRANCH_PENALTY cycles) and
// whole-pipeline freeze while data memory is busy. A branch seen during
// a freeze is latched in pend and serviced on the first non-busy cycle.
// Priority: freeze > branch > load-use.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating 32-bit
// stallCycles / flushCycles / freezeCycles counters.
// dbg_state / dbg_cnt / dbg_pend expose the sequencer state for checkers.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFIDrs1,
  input  logic [REG_W-1:0] IFIDrs2,
  input  logic [REG_W-1:0] IDEXrd,
  input  logic             IDEXmemRead,
  input  logic             branchTaken,
  input  logic             memBusy,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IDEXwrite,
  output logic             EXMEMwrite,
  output logic             IFIDflush,
  output logic             IDEXbubble,
  output logic             redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      stallCycles,
  output logic [31:0]      flushCycles,
  output logic [31:0]      freezeCycles,
`endif
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_cnt,
  output logic             dbg_pend
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             lu_hazard;
  logic             stall_now, flush_now, freeze_now;

  load_use_detect u_lud (
    .rs1         (IFIDrs1),
    .rs2         (IFIDrs2),
    .ex_rd       (IDEXrd),
    .ex_mem_read (IDEXmemRead),
    .hazard      (lu_hazard)
  );

  // Sequencer state register; reset aborts any flush and drops pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and combinational pipeline controls, in priority order.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    PCwrite    = 1'b1;
    IFIDwrite  = 1'b1;
    IDEXwrite  = 1'b1;
    EXMEMwrite = 1'b1;
    IFIDflush  = 1'b0;
    IDEXbubble = 1'b0;
    redirect   = 1'b0;
    stall_now  = 1'b0;
    flush_now  = 1'b0;
    freeze_now = 1'b0;
    if (!rst_n) begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXwrite  = 1'b0;
      EXMEMwrite = 1'b0;
      IFIDflush  = 1'b1;
      IDEXbubble = 1'b1;
    end else if (memBusy) begin
      freeze_now = 1'b1;
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXwrite  = 1'b0;
      EXMEMwrite = 1'b0;
      if (state_q == RUN && branchTaken) pend_d = 1'b1;
    end else if (state_q == FLUSH) begin
      // Wrong-path instructions: branches and load-use are ignored here.
      flush_now  = 1'b1;
      IFIDflush  = 1'b1;
      IDEXbubble = 1'b1;
      if (cnt_q == '0) state_d = RUN;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end else if (branchTaken || pend_q) begin
      flush_now  = 1'b1;
      redirect   = 1'b1;
      IFIDflush  = 1'b1;
      IDEXbubble = 1'b1;
      pend_d     = 1'b0;
      if (BRANCH_PENALTY > 1) begin
        state_d = FLUSH;
        cnt_d   = CNT_W'(BRANCH_PENALTY - 2);
      end
    end else if (lu_hazard) begin
      stall_now  = 1'b1;
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXbubble = 1'b1;
    end
  end

  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_pend  = pend_q;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating cycle counters for each hazard condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles  <= '0;
      flushCycles  <= '0;
      freezeCycles <= '0;
    end else begin
      if (stall_now)  stallCycles  <= sat_inc(stallCycles);
      if (flush_now)  flushCycles  <= sat_inc(flushCycles);
      if (freeze_now) freezeCycles <= sat_inc(freezeCycles);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = stall_now ^ flush_now ^ freeze_now;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit (BRANCH_PENALTY=3): directed steps from
// the test plan followed by random traffic, checked against a
// cycle-level reference model of the pipeline-control rules.
module tb_hazard_control_unit;
  localparam int BP    = 3;
  localparam int CNT_W = 4;

  // Control vector order: {PCwrite,IFIDwrite,IDEXwrite,EXMEMwrite,IFIDflush,IDEXbubble,redirect}
  localparam logic [6:0] V_RESET  = 7'b0000110;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_BRANCH = 7'b1111111;
  localparam logic [6:0] V_FLUSH  = 7'b1111110;
  localparam logic [6:0] V_STALL  = 7'b0011010;
  localparam logic [6:0] V_IDLE   = 7'b1111000;

  // Clock / reset and DUT signals
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] IFIDrs1 = '0, IFIDrs2 = '0, IDEXrd = '0;
  logic IDEXmemRead = 1'b0, branchTaken = 1'b0, memBusy = 1'b0;
  logic PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, IFIDflush, IDEXbubble, redirect;
  logic dbg_state, dbg_pend;
  logic [CNT_W-1:0] dbg_cnt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles, flushCycles, freezeCycles;
  int m_stall = 0, m_flush = 0, m_freeze = 0;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.BRANCH_PENALTY(BP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IDEXrd(IDEXrd),
    .IDEXmemRead(IDEXmemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .IDEXwrite(IDEXwrite),
    .EXMEMwrite(EXMEMwrite), .IFIDflush(IFIDflush), .IDEXbubble(IDEXbubble),
    .redirect(redirect),
`ifdef HAZARD_PERF_CNT_EN
    .stallCycles(stallCycles), .flushCycles(flushCycles), .freezeCycles(freezeCycles),
`endif
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt), .dbg_pend(dbg_pend)
  );

  // Reference model: flush cycles still owed after the redirect cycle, plus latched branch.
  int   flush_left = 0;
  logic m_pend = 1'b0;

  // Scoreboard
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [6:0] ctl_vec();
    return {PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, IFIDflush, IDEXbubble, redirect};
  endfunction

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Driver: apply one cycle of inputs at the negedge, check, advance the model.
  task automatic step(input string tag, input logic br, input logic busy,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2);
    logic haz;
    logic [6:0] e;
    branchTaken = br; memBusy = busy; IDEXmemRead = mr;
    IDEXrd = rd; IFIDrs1 = rs1; IFIDrs2 = rs2;
    #1;
    haz = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (busy)                 e = V_FREEZE;
    else if (flush_left > 0)  e = V_FLUSH;
    else if (br || m_pend)    e = V_BRANCH;
    else if (haz)             e = V_STALL;
    else                      e = V_IDLE;
    exp_q.push_back(e);
    check_vec({tag, ".ctl"}, ctl_vec(), exp_q.pop_front());
    check_bit({tag, ".flushing"}, dbg_state, flush_left > 0);
    check_bit({tag, ".pend"}, dbg_pend, m_pend);
    // Model advance for the coming rising edge
    if (busy) begin
      if (flush_left == 0 && br) m_pend = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      m_freeze++;
`endif
    end else if (flush_left > 0) begin
      flush_left--;
`ifdef HAZARD_PERF_CNT_EN
      m_flush++;
`endif
    end else if (br || m_pend) begin
      m_pend = 1'b0;
      flush_left = BP - 1;
`ifdef HAZARD_PERF_CNT_EN
      m_flush++;
`endif
    end else if (haz) begin
`ifdef HAZARD_PERF_CNT_EN
      m_stall++;
`endif
    end
    @(negedge clk);
  endtask

  // Assert reset asynchronously mid-cycle, check forced outputs, release next negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_vec({tag, ".ctl"}, ctl_vec(), V_RESET);
    check_bit({tag, ".flushing"}, dbg_state, 1'b0);
    check_bit({tag, ".pend"}, dbg_pend, 1'b0);
    flush_left = 0;
    m_pend = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 0; m_flush = 0; m_freeze = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset0");

    // Load-use on rs2, then the bubble clears IDEXmemRead
    step("lu_stall",  1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5);
    step("lu_after",  1'b0, 1'b0, 1'b0, 5'd5, 5'd1, 5'd5);
    // Same with rd = x0: no stall
    step("lu_x0",     1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    step("lu_rs1",    1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2);
    // Branch: redirect one cycle, flush three cycles, RUN on cycle 4
    step("br_entry",  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("br_fl1",    1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0);
    step("br_fl2",    1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("br_run",    1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    // Branch during a 4-cycle freeze: latched, serviced on first free cycle
    step("fz_br",     1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step("fz_2",      1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
    step("fz_3",      1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step("fz_4",      1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step("fz_redir",  1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("fz_fl1",    1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("fz_fl2",    1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    // Branch and load-use together: branch wins
    step("br_lu",     1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
    // Reset mid-flush (counter at 1), then idle RUN
    do_reset("reset_flush");
    step("post_rst",  1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("post_rst2", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    end

`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    assert (stallCycles === 32'(m_stall)) else begin
      n_fails++; $error("FAIL perf.stall observed=%0d expected=%0d", stallCycles, m_stall);
    end
    n_checks++;
    assert (flushCycles === 32'(m_flush)) else begin
      n_fails++; $error("FAIL perf.flush observed=%0d expected=%0d", flushCycles, m_flush);
    end
    n_checks++;
    assert (freezeCycles === 32'(m_freeze)) else begin
      n_fails++; $error("FAIL perf.freeze observed=%0d expected=%0d", freezeCycles, m_freeze);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
